// File: rtl/proc_pkg.sv
// Shared definitions for the 5-stage core front end: widths, the NOP encoding
// and the bubble value loaded into ID/EX on reset or flush.
package proc_pkg;

  localparam int unsigned REG_ADR_W   = 3;
  localparam int unsigned DEF_PC_W    = 16;
  localparam int unsigned DEF_INSTR_W = 16;

  localparam logic [DEF_INSTR_W-1:0] NOP = '0;

  // Control and address fields a bubble carries: nothing is read or written.
  localparam logic                 CTRL_RST = 1'b0;
  localparam logic [REG_ADR_W-1:0] ADR_RST  = '0;

  typedef struct packed {
    logic [REG_ADR_W-1:0] rs1;
    logic [REG_ADR_W-1:0] rs2;
    logic [REG_ADR_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 valid;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    rs1:        ADR_RST,
    rs2:        ADR_RST,
    rd:         ADR_RST,
    reg_write:  CTRL_RST,
    mem_to_reg: CTRL_RST,
    mem_write:  CTRL_RST,
    valid:      1'b0
  };

endpackage

// File: rtl/pipe_front_regs_if.sv
// Hazard-control interface: the hazard unit (master) issues stall/flush/redirect
// commands and reads back the E-stage register addresses and controls.
interface pipe_front_regs_if;
  import proc_pkg::*;

  logic                 stall_f;
  logic                 stall_d;
  logic                 flush_d;
  logic                 flush_e;
  logic                 PC_source;

  logic [REG_ADR_W-1:0] reg_read_adr1_e;
  logic [REG_ADR_W-1:0] reg_read_adr2_e;
  logic [REG_ADR_W-1:0] reg_write_adr_e;
  logic                 reg_write_e;
  logic                 mem_to_reg_e;
  logic                 mem_write_e;
  logic                 valid_e;

  modport master (
    output stall_f, stall_d, flush_d, flush_e, PC_source,
    input  reg_read_adr1_e, reg_read_adr2_e, reg_write_adr_e,
    input  reg_write_e, mem_to_reg_e, mem_write_e, valid_e
  );

  modport slave (
    input  stall_f, stall_d, flush_d, flush_e, PC_source,
    output reg_read_adr1_e, reg_read_adr2_e, reg_write_adr_e,
    output reg_write_e, mem_to_reg_e, mem_write_e, valid_e
  );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register with clear (bubble insert) and enable (stall).
// Clear wins over enable; clear and reset load the same value.
module pipe_reg #(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register: reset/clear to bubble, else load when enabled, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_front_regs.sv
// Front-end pipeline state of the 5-stage core: PC, IF/ID and ID/EX registers.
// Responder side of the hazard-control interface.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
module pipe_front_regs
  import proc_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter int unsigned     INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_front_regs_if.slave     hz,
  input  logic [PC_W-1:0]      pc_branch,
  input  logic [INSTR_W-1:0]   instr_f,
  input  logic [REG_ADR_W-1:0] reg_read_adr1_d,
  input  logic [REG_ADR_W-1:0] reg_read_adr2_d,
  input  logic [REG_ADR_W-1:0] reg_write_adr_d,
  input  logic                 reg_write_d,
  input  logic                 mem_to_reg_d,
  input  logic                 mem_write_d,
  output logic [PC_W-1:0]      pc_f,
  output logic [INSTR_W-1:0]   instr_d,
  output logic [PC_W-1:0]      pc_plus1_d,
  output logic                 valid_d,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          flush_cnt
);

  localparam int unsigned IF_ID_W = INSTR_W + PC_W + 1;
  localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = {INSTR_W'(NOP), PC_W'(0), 1'b0};

  logic [PC_W-1:0]    pc_inc;
  logic [IF_ID_W-1:0] if_id_d;
  logic [IF_ID_W-1:0] if_id_q;
  id_ex_t             id_ex_d;
  id_ex_t             id_ex_q;

  // Word-addressed PC; wrap from all-ones to zero is intended.
  assign pc_inc = pc_f + PC_W'(1);

  // PC: redirect beats stall so a taken branch is never dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else if (hz.PC_source) begin
      pc_f <= pc_branch;
    end else if (!hz.stall_f) begin
      pc_f <= pc_inc;
    end
  end

  assign if_id_d = {instr_f, pc_inc, 1'b1};

  pipe_reg #(
    .W       (IF_ID_W),
    .RST_VAL (IF_ID_BUBBLE)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .en    (~hz.stall_d),
    .clr   (hz.flush_d),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign {instr_d, pc_plus1_d, valid_d} = if_id_q;

  assign id_ex_d = '{
    rs1:        reg_read_adr1_d,
    rs2:        reg_read_adr2_d,
    rd:         reg_write_adr_d,
    reg_write:  reg_write_d,
    mem_to_reg: mem_to_reg_d,
    mem_write:  mem_write_d,
    valid:      valid_d
  };

  // ID/EX never stalls: it either loads the D stage or takes a bubble.
  pipe_reg #(
    .W       ($bits(id_ex_t)),
    .RST_VAL (ID_EX_BUBBLE)
  ) u_id_ex (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (hz.flush_e),
    .d     (id_ex_d),
    .q     (id_ex_q)
  );

  assign hz.reg_read_adr1_e = id_ex_q.rs1;
  assign hz.reg_read_adr2_e = id_ex_q.rs2;
  assign hz.reg_write_adr_e = id_ex_q.rd;
  assign hz.reg_write_e     = id_ex_q.reg_write;
  assign hz.mem_to_reg_e    = id_ex_q.mem_to_reg;
  assign hz.mem_write_e     = id_ex_q.mem_write;
  assign hz.valid_e         = id_ex_q.valid;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.stall_d && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if ((hz.flush_d || hz.flush_e) && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench for pipe_front_regs: directed hazard scenarios plus
// randomized command streams checked against a cycle-level reference model.
module tb_pipe_front_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc_branch = '0;
  logic [15:0] instr_f = '0;
  logic [2:0]  reg_read_adr1_d = '0;
  logic [2:0]  reg_read_adr2_d = '0;
  logic [2:0]  reg_write_adr_d = '0;
  logic        reg_write_d = 1'b0;
  logic        mem_to_reg_d = 1'b0;
  logic        mem_write_d = 1'b0;
  logic [15:0] pc_f;
  logic [15:0] instr_d;
  logic [15:0] pc_plus1_d;
  logic        valid_d;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  pipe_front_regs_if hz ();

  pipe_front_regs dut (
    .clk             (clk),
    .reset           (reset),
    .hz              (hz),
    .pc_branch       (pc_branch),
    .instr_f         (instr_f),
    .reg_read_adr1_d (reg_read_adr1_d),
    .reg_read_adr2_d (reg_read_adr2_d),
    .reg_write_adr_d (reg_write_adr_d),
    .reg_write_d     (reg_write_d),
    .mem_to_reg_d    (mem_to_reg_d),
    .mem_write_d     (mem_write_d),
    .pc_f            (pc_f),
    .instr_d         (instr_d),
    .pc_plus1_d      (pc_plus1_d),
    .valid_d         (valid_d),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state, advanced once per rising edge.
  logic [15:0] m_pc, m_instr_d, m_pcp1;
  logic        m_vd;
  logic [2:0]  m_a1, m_a2, m_wa;
  logic        m_rw, m_mr, m_mw, m_ve;
  int          m_sc, m_fc;

  logic [93:0] dut_vec;
  assign dut_vec = {pc_f, instr_d, pc_plus1_d, valid_d, hz.reg_read_adr1_e,
                    hz.reg_read_adr2_e, hz.reg_write_adr_e, hz.reg_write_e,
                    hz.mem_to_reg_e, hz.mem_write_e, hz.valid_e, stall_cnt, flush_cnt};

  function automatic logic [93:0] model_vec();
    logic [15:0] sc, fc;
`ifdef PIPE_PERF_CNT_EN
    sc = 16'(m_sc);
    fc = 16'(m_fc);
`else
    sc = 16'd0;
    fc = 16'd0;
`endif
    return {m_pc, m_instr_d, m_pcp1, m_vd, m_a1, m_a2, m_wa, m_rw, m_mr, m_mw, m_ve, sc, fc};
  endfunction

  task automatic model_reset();
    m_pc = 16'd0; m_instr_d = 16'd0; m_pcp1 = 16'd0; m_vd = 1'b0;
    m_a1 = 3'd0; m_a2 = 3'd0; m_wa = 3'd0;
    m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_ve = 1'b0;
    m_sc = 0; m_fc = 0;
  endtask

  task automatic model_step();
    // E stage sees the old D-stage valid.
    if (hz.flush_e) begin
      {m_a1, m_a2, m_wa, m_rw, m_mr, m_mw, m_ve} = '0;
    end else begin
      {m_a1, m_a2, m_wa} = {reg_read_adr1_d, reg_read_adr2_d, reg_write_adr_d};
      {m_rw, m_mr, m_mw} = {reg_write_d, mem_to_reg_d, mem_write_d};
      m_ve = m_vd;
    end
    if (hz.flush_d) begin
      m_instr_d = 16'd0; m_pcp1 = 16'd0; m_vd = 1'b0;
    end else if (!hz.stall_d) begin
      m_instr_d = instr_f; m_pcp1 = m_pc + 16'd1; m_vd = 1'b1;
    end
    if (hz.PC_source) m_pc = pc_branch;
    else if (!hz.stall_f) m_pc = m_pc + 16'd1;
    if (hz.stall_d && m_sc < 65535) m_sc++;
    if ((hz.flush_d || hz.flush_e) && m_fc < 65535) m_fc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cmds();
    hz.stall_f = 1'b0; hz.stall_d = 1'b0; hz.flush_d = 1'b0;
    hz.flush_e = 1'b0; hz.PC_source = 1'b0;
  endtask

  // Pulse reset between edges and resynchronise the model.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_cmds();
    reg_write_d = 1'b1; mem_write_d = 1'b1; reg_write_adr_d = 3'd5;
    do_reset();
    n_cmp++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", dut_vec, model_vec());
    end
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (pc_f !== 16'h0007 || hz.reg_write_e !== 1'b1) begin
      n_fail++; $display("FAIL run_to_7 pc_f=%h rw_e=%b want 0007/1", pc_f, hz.reg_write_e);
    end
    reset = 1'b1;
    model_reset();
    #2;
    n_cmp++;
    if (pc_f !== 16'h0 || valid_d !== 1'b0 || hz.valid_e !== 1'b0 || hz.reg_write_e !== 1'b0)
    begin
      n_fail++;
      $display("FAIL async_reset pc_f=%h vd=%b ve=%b rw_e=%b want 0/0/0/0", pc_f, valid_d,
               hz.valid_e, hz.reg_write_e);
    end
    reset = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_cmp++;
      if (pc_f !== 16'(i) || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL post_reset_step%0d pc_f=%h want %h", i, pc_f, 16'(i));
      end
    end
  endtask

  task automatic test_load_use();
    idle_cmds();
    do_reset();
    instr_f = 16'h1234;
    reg_read_adr1_d = 3'd3; reg_read_adr2_d = 3'd5; reg_write_adr_d = 3'd6;
    reg_write_d = 1'b1; mem_to_reg_d = 1'b1; mem_write_d = 1'b0;
    tick();
    n_cmp++;
    if (instr_d !== 16'h1234 || valid_d !== 1'b1) begin
      n_fail++; $display("FAIL lu_latch instr_d=%h vd=%b want 1234/1", instr_d, valid_d);
    end
    hz.stall_f = 1'b1; hz.stall_d = 1'b1; hz.flush_e = 1'b1;
    instr_f = 16'hBEEF;
    tick();
    n_cmp++;
    if (instr_d !== 16'h1234 || pc_f !== 16'h0001 || hz.valid_e !== 1'b0 ||
        hz.mem_to_reg_e !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall instr_d=%h pc_f=%h ve=%b mr_e=%b want 1234/0001/0/0", instr_d,
               pc_f, hz.valid_e, hz.mem_to_reg_e);
    end
    idle_cmds();
    tick();
    n_cmp++;
    if (hz.valid_e !== 1'b1 || hz.mem_to_reg_e !== 1'b1 || hz.reg_write_adr_e !== 3'd6 ||
        hz.reg_read_adr1_e !== 3'd3 || pc_f !== 16'h0002) begin
      n_fail++;
      $display("FAIL lu_resume ve=%b mr_e=%b rd_e=%0d rs1_e=%0d pc_f=%h want 1/1/6/3/0002",
               hz.valid_e, hz.mem_to_reg_e, hz.reg_write_adr_e, hz.reg_read_adr1_e, pc_f);
    end
  endtask

  task automatic test_branch();
    idle_cmds();
    do_reset();
    tick(); tick();
    hz.PC_source = 1'b1; pc_branch = 16'h0040; hz.flush_d = 1'b1; hz.flush_e = 1'b1;
    tick();
    n_cmp++;
    if (pc_f !== 16'h0040 || valid_d !== 1'b0 || hz.valid_e !== 1'b0) begin
      n_fail++;
      $display("FAIL br_redirect pc_f=%h vd=%b ve=%b want 0040/0/0", pc_f, valid_d, hz.valid_e);
    end
    idle_cmds();
    tick();
    n_cmp++;
    if (pc_f !== 16'h0041 || pc_plus1_d !== 16'h0041 || valid_d !== 1'b1 ||
        hz.valid_e !== 1'b0) begin
      n_fail++;
      $display("FAIL br_target pc_f=%h pcp1_d=%h vd=%b ve=%b want 0041/0041/1/0", pc_f,
               pc_plus1_d, valid_d, hz.valid_e);
    end
  endtask

  task automatic test_priority();
    idle_cmds();
    do_reset();
    instr_f = 16'hA5A5;
    tick();
    hz.PC_source = 1'b1; hz.stall_f = 1'b1; pc_branch = 16'h1357;
    hz.flush_d = 1'b1; hz.stall_d = 1'b1;
    tick();
    n_cmp++;
    if (pc_f !== 16'h1357 || instr_d !== 16'h0 || pc_plus1_d !== 16'h0 || valid_d !== 1'b0)
    begin
      n_fail++;
      $display("FAIL priority pc_f=%h instr_d=%h pcp1_d=%h vd=%b want 1357/0/0/0", pc_f,
               instr_d, pc_plus1_d, valid_d);
    end
  endtask

  task automatic test_wrap();
    idle_cmds();
    do_reset();
    hz.PC_source = 1'b1; pc_branch = 16'hFFFF;
    tick();
    idle_cmds();
    tick();
    n_cmp++;
    if (pc_f !== 16'h0000 || pc_plus1_d !== 16'h0000 || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap pc_f=%h pcp1_d=%h vd=%b want 0000/0000/1", pc_f, pc_plus1_d, valid_d);
    end
  endtask

  task automatic test_random();
    idle_cmds();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      hz.stall_f   = ($urandom_range(3) == 0);
      hz.stall_d   = ($urandom_range(3) == 0);
      hz.flush_d   = ($urandom_range(4) == 0);
      hz.flush_e   = ($urandom_range(4) == 0);
      hz.PC_source = ($urandom_range(5) == 0);
      pc_branch = 16'($urandom);
      instr_f = 16'($urandom);
      reg_read_adr1_d = 3'($urandom);
      reg_read_adr2_d = 3'($urandom);
      reg_write_adr_d = 3'($urandom);
      reg_write_d = 1'($urandom);
      mem_to_reg_d = 1'($urandom);
      mem_write_d = 1'($urandom);
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    idle_cmds();
  endtask

  task automatic test_counters();
    idle_cmds();
    do_reset();
`ifdef PIPE_PERF_CNT_EN
    hz.flush_d = 1'b1; hz.flush_e = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    hz.flush_d = 1'b0;
    tick();
    n_cmp++;
    if (flush_cnt !== 16'd4 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_cnt got=%h/%h want 0004/0000", flush_cnt, stall_cnt);
    end
    hz.flush_e = 1'b0; hz.stall_d = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd4) begin
      n_fail++; $display("FAIL stall_sat got=%h/%h want FFFF/0004", stall_cnt, flush_cnt);
    end
    n_cmp++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL cnt_state got=%h want=%h", dut_vec, model_vec());
    end
`else
    for (int i = 0; i < 20; i++) begin
      hz.stall_d = 1'($urandom);
      hz.flush_d = 1'($urandom);
      hz.flush_e = 1'($urandom);
      tick();
      n_cmp++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
        n_fail++; $display("FAIL cnt_tied got=%h/%h want 0000/0000", stall_cnt, flush_cnt);
      end
    end
`endif
    idle_cmds();
  endtask

  initial begin
    idle_cmds();
    model_reset();
    #2;
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_wrap();
    test_random();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
